mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_arb2.sv | 65 ++++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-requester memory arbiter.
//   owner_e            : which requester owns an in-flight read (FETCH=0, DATA=1)
//   DEFAULT_WIDTH      : default data word width
//   DEFAULT_WIDTH_BITS : default word-address width
//   REQ_FETCH/REQ_DATA : bit positions inside the 2-bit request/grant vectors
//                        used between mem_arbiter and mem_arbiter_arb2
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_WIDTH_BITS = 30;

    // Request/grant vector bit positions match the owner encoding so a grant
    // bit can be turned straight into an owner value.
    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;

    // Converts a one-hot read grant into the owner that will receive the data.
    function automatic owner_e owner_from_gnt(input logic [1:0] gnt);
        owner_e result;
        result = gnt[REQ_DATA] ? OWNER_DATA : OWNER_FETCH;
        return result;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb2.sv
// -----------------------------------------------------------------------------
// mem_arbiter_arb2
// Two-way read arbiter. Grants at most one of the two read requests per cycle,
// returning a one-hot (or zero) grant vector.
//   clk, rst_n : clock / asynchronous active-low reset (round-robin build only)
//   req[1:0]   : read requests, bit REQ_FETCH = fetch, bit REQ_DATA = data
//   gnt[1:0]   : one-hot grant, same bit layout as req
// Build option:
//   MEM_ARBITER_RR_EN defined   -> round-robin on conflicts, with a 1-bit
//                                  last-winner register
//   MEM_ARBITER_RR_EN undefined -> fixed priority, data always wins conflicts
// -----------------------------------------------------------------------------
module mem_arbiter_arb2
    import mem_arbiter_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic conflict;

    assign conflict = req[REQ_FETCH] & req[REQ_DATA];

`ifdef MEM_ARBITER_RR_EN
    owner_e last_winner;

    // The requester that lost the previous conflict wins this one. Reset to
    // FETCH so the very first conflict goes to the data side.
    always_comb begin
        gnt = req;
        if (conflict) begin
            gnt = '0;
            if (last_winner == OWNER_FETCH) begin
                gnt[REQ_DATA] = 1'b1;
            end else begin
                gnt[REQ_FETCH] = 1'b1;
            end
        end
    end

    // Only real conflicts move the round-robin pointer; uncontested grants
    // leave it alone so the alternation is between contested cycles only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= OWNER_FETCH;
        end else if (conflict) begin
            last_winner <= owner_from_gnt(gnt);
        end
    end
`else
    // Fixed priority: on a conflict the data side wins and fetch waits.
    always_comb begin
        gnt = req;
        if (conflict) begin
            gnt = '0;
            gnt[REQ_DATA] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory (1-cycle registered read port + independent write port)
// between an instruction-fetch requester (read only) and a data requester
// (read or write).
// Parameters:
//   WIDTH      : data word width
//   WIDTH_BITS : word-address width
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_req, i_addr              : fetch request / address
//   i_gnt, i_rvalid, i_rdata   : fetch grant, read response valid / data
//   d_req, d_we, d_addr,
//   d_wdata                    : data request, write enable, address, write data
//   d_gnt, d_rvalid, d_rdata   : data grant, read response valid / data
//   m_ren, m_raddr             : memory read enable / address
//   m_wen, m_waddr, m_wdata    : memory write enable / address / data
//   m_rdata                    : memory read data (one cycle after m_ren)
// Build option:
//   MEM_ARBITER_RR_EN : round-robin read conflict resolution (otherwise data
//                       has fixed priority over fetch)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int WIDTH_BITS = DEFAULT_WIDTH_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req,
    input  logic [WIDTH_BITS-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [WIDTH-1:0]      i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WIDTH_BITS-1:0] d_addr,
    input  logic [WIDTH-1:0]      d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WIDTH-1:0]      d_rdata,

    output logic                  m_ren,
    output logic [WIDTH_BITS-1:0] m_raddr,
    output logic                  m_wen,
    output logic [WIDTH_BITS-1:0] m_waddr,
    output logic [WIDTH-1:0]      m_wdata,
    input  logic [WIDTH-1:0]      m_rdata
);

    logic                  d_write;
    logic                  d_read;
    logic [1:0]            rd_req;
    logic [1:0]            rd_gnt;
    logic                  read_grant;
    logic [WIDTH_BITS-1:0] raddr_q;
    owner_e                owner;
    logic                  rd_pending;

    // Split the data request into its write and read halves. Writes use
    // their own memory port, so only reads ever go through arbitration.
    assign d_write = d_req & d_we;
    assign d_read  = d_req & ~d_we;

    assign rd_req[REQ_FETCH] = i_req;
    assign rd_req[REQ_DATA]  = d_read;

    mem_arbiter_arb2 u_arb2 (
`ifdef MEM_ARBITER_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    // Grants and memory controls are combinational so a requester can be
    // served in the cycle it asks. Everything is held off while reset is
    // asserted. When no read is granted the read address is taken from the
    // register instead, so m_raddr never goes X and stays at its last value.
    // Reads are never forwarded from a same-cycle write: the memory returns
    // the old contents.
    always_comb begin
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        m_ren      = 1'b0;
        m_wen      = 1'b0;
        read_grant = 1'b0;
        m_raddr    = raddr_q;
        m_waddr    = d_addr;
        m_wdata    = d_wdata;
        if (rst_n) begin
            read_grant = rd_gnt[REQ_FETCH] | rd_gnt[REQ_DATA];
            i_gnt      = rd_gnt[REQ_FETCH];
            d_gnt      = rd_gnt[REQ_DATA] | d_write;
            m_wen      = d_write;
            m_ren      = read_grant;
            if (rd_gnt[REQ_DATA]) begin
                m_raddr = d_addr;
            end else if (rd_gnt[REQ_FETCH]) begin
                m_raddr = i_addr;
            end
        end
    end

    // Remember the last read address so m_raddr holds steady between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= m_raddr;
        end
    end

    // Response pipeline: each granted read marks rd_pending for exactly the
    // next cycle and records who asked. Reset clears the pending flag, so a
    // read granted just before reset never produces a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            owner      <= OWNER_FETCH;
        end else begin
            rd_pending <= read_grant;
            if (read_grant) begin
                owner <= owner_from_gnt(rd_gnt);
            end
        end
    end

    // Both requesters see the raw memory data; only the owner's rvalid
    // qualifies it.
    assign i_rvalid = rd_pending & (owner == OWNER_FETCH);
    assign d_rvalid = rd_pending & (owner == OWNER_DATA);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
